if_fetch_queue: RTL

Parametrised instruction-fetch stage with a decoupling prefetch queue. It drives a synchronous instruction memory with a one-cycle read latency, and buffers up to DEPTH fetched instructions with their addresses. It presents them to decode through a valid/ready handshake, and flushes on an absolute jump. It sits between the instruction ROM and the IF/ID pipeline register, and replaces the stall-gated PC-plus-combinational-memory fetch path.

---
 rtl/if_fetch_queue.sv | 130 +++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues one-cycle-latency ROM reads and buffers up to DEPTH {addr, instr} entries for decode.
// Optional feature: define IF_FETCH_CNT_EN to add the 16-bit fetchCount output, which counts accepted instructions.
module if_fetch_queue #(
  parameter int MEM_WIDTH = 8,
  parameter int WIDTH     = 16,
  parameter int OFF_WIDTH = 6,
  parameter int DEPTH     = 4,
  parameter logic [MEM_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 jump,
  input  logic [OFF_WIDTH-1:0] jumpOffset,
  output logic [MEM_WIDTH-1:0] memAddr,
  output logic                 memReq,
  input  logic [WIDTH-1:0]     memData,
  output logic [WIDTH-1:0]     instr,
  output logic [MEM_WIDTH-1:0] instrAddr,
  output logic                 instrValid,
  input  logic                 instrReady
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [15:0]          fetchCount
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [MEM_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]     rd_q, rd_d;
  logic [PTR_W-1:0]     wr_q, wr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 inflight_q, inflight_d;
  logic [MEM_WIDTH-1:0] inflight_addr_q, inflight_addr_d;
  logic [MEM_WIDTH-1:0] addr_mem_q [DEPTH];
  logic [WIDTH-1:0]     data_mem_q [DEPTH];

  logic                 pop;
  logic                 issue;
  logic                 capture;
  logic [OCC_W-1:0]     occupancy;

  // Handshake and issue decisions; jump and reset both suppress issue and pop in the same cycle.
  always_comb begin
    instrValid = ~reset & ~jump & (count_q != '0);
    pop        = instrValid & instrReady;
    capture    = ~reset & ~jump & inflight_q;
    // A pop this cycle frees a slot immediately, so issue resumes without a bubble.
    occupancy  = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue      = ~reset & ~jump & (occupancy < OCC_W'(DEPTH));
    memReq     = issue;
    memAddr    = reset ? RESET_PC : fetch_pc_q;
    instr      = reset ? '0 : data_mem_q[rd_q];
    instrAddr  = reset ? '0 : addr_mem_q[rd_q];
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    fetch_pc_d      = fetch_pc_q;
    rd_d            = rd_q;
    wr_d            = wr_q;
    count_d         = count_q;
    inflight_d      = inflight_q;
    inflight_addr_d = inflight_addr_q;

    if (jump) begin
      fetch_pc_d = MEM_WIDTH'($signed(jumpOffset));
      count_d    = '0;
      rd_d       = wr_q;
      inflight_d = 1'b0;
    end else begin
      inflight_d = issue;
      if (issue) begin
        fetch_pc_d      = fetch_pc_q + MEM_WIDTH'(1);
        inflight_addr_d = fetch_pc_q;
      end
      if (capture) wr_d = wr_q + PTR_W'(1);
      if (pop)     rd_d = rd_q + PTR_W'(1);
      if (capture && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !capture) count_d = count_q - CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q      <= RESET_PC;
      rd_q            <= '0;
      wr_q            <= '0;
      count_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
      // NOTE: the storage is cleared too, so the head reads zero after reset rather than stale entries.
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      fetch_pc_q      <= fetch_pc_d;
      rd_q            <= rd_d;
      wr_q            <= wr_d;
      count_q         <= count_d;
      inflight_q      <= inflight_d;
      inflight_addr_q <= inflight_addr_d;
      if (capture) begin
        addr_mem_q[wr_q] <= inflight_addr_q;
        data_mem_q[wr_q] <= memData;
      end
    end
  end

`ifdef IF_FETCH_CNT_EN
  logic [15:0] fetch_cnt_q, fetch_cnt_d;

  // Counts accepted instructions; a jump does not clear it.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q + 16'(pop);
  end

  always_ff @(posedge clk) begin
    if (reset) fetch_cnt_q <= '0;
    else       fetch_cnt_q <= fetch_cnt_d;
  end

  assign fetchCount = fetch_cnt_q;
`endif

endmodule
